soc1_sysid_arbiter: RTL and testbench

SOC1_SYSID_ARBITER -- requirements
Module: soc1_sysid_arbiter

---
 rtl/soc1_sysid_arbiter.sv | 121 ++++++++++++
 tb/tb_soc1_sysid_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc1_sysid_arbiter.sv
// Two-master read arbiter in front of a single shared read-only slave.
// One transaction is in flight at a time. On a tie the master that did not
// win last time is granted. Slave data is captured READ_LATENCY cycles after
// the s_read strobe and returned to the granted master as a one-cycle strobe.
//
// Handshake: a master holds mX_read (and mX_address) until it sees
// mX_waitrequest low in the same cycle; that cycle is the acceptance. Return
// data is flagged by a single-cycle mX_readdatavalid, with no backpressure.
module soc1_sysid_arbiter #(
    parameter int ADDR_W       = 1,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1   // legal range 0..3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              gnt;          // master owning the outstanding transaction
    logic              last_grant;   // master granted most recently
    logic [ADDR_W-1:0] addr_q;       // address latched at acceptance
    logic [DATA_W-1:0] data_q;       // last data captured from the slave
    logic [1:0]        cnt;          // cycles left until slave data is valid
    logic              grant_valid;
    logic              grant_sel;

    // Arbitration for the current cycle; only in IDLE and never while in reset
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state == IDLE && !reset) begin
            if (m0_read && m1_read) begin
                grant_valid = 1'b1;
                grant_sel   = ~last_grant;
            end else if (m0_read) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (m1_read) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = (READ_LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 2'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, grant bookkeeping, address latch and data capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            cnt        <= 2'd0;
        end else begin
            state <= state_next;
            if (grant_valid) begin
                gnt        <= grant_sel;
                last_grant <= grant_sel;
                addr_q     <= grant_sel ? m1_address : m0_address;
            end
            if (state == ISSUE) begin
                if (READ_LATENCY == 0) begin
                    data_q <= s_readdata;
                end else begin
                    cnt <= 2'(READ_LATENCY);
                end
            end
            if (state == WAIT) begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1) begin
                    data_q <= s_readdata;
                end
            end
        end
    end

    assign m0_waitrequest   = ~(grant_valid && !grant_sel);
    assign m1_waitrequest   = ~(grant_valid && grant_sel);
    assign m0_readdatavalid = (state == RESP) && !gnt;
    assign m1_readdatavalid = (state == RESP) && gnt;
    assign m0_readdata      = data_q;
    assign m1_readdata      = data_q;
    assign s_read           = (state == ISSUE);
    assign s_address        = addr_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_soc1_sysid_arbiter.sv
// Bench for soc1_sysid_arbiter: four lanes, one per READ_LATENCY 0..3, each
// with its own latency-accurate slave. Lanes are exercised one after another
// with randomized master traffic and random resets, and every cycle is
// compared against a transaction-level reference model.
module tb_soc1_sysid_arbiter;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        m0_address       [N];
    logic        m0_read          [N];
    logic        m0_waitrequest   [N];
    logic [31:0] m0_readdata      [N];
    logic        m0_readdatavalid [N];
    logic        m1_address       [N];
    logic        m1_read          [N];
    logic        m1_waitrequest   [N];
    logic [31:0] m1_readdata      [N];
    logic        m1_readdatavalid [N];
    logic        s_address        [N];
    logic        s_read           [N];
    logic [31:0] s_readdata       [N];
    logic        busy             [N];

    function automatic logic [31:0] slave_val(input logic a);
        return a ? 32'h671B1880 : 32'h0000_0000;
    endfunction

    // ---------------- DUT lanes with slave models ----------------
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [2:0]  vpipe = '0;
        logic [2:0]  apipe = '0;
        logic [31:0] junk  = 32'hDEAD_BEEF;
        logic        sv;
        logic        sa;

        // Slave pipeline: remembers strobes/addresses, drives junk when not valid
        always @(posedge clock) begin
            vpipe <= {vpipe[1:0], s_read[g]};
            apipe <= {apipe[1:0], s_address[g]};
            junk  <= $urandom;
        end

        if (g == 0) begin : g_l0
            assign sv = s_read[g];
            assign sa = s_address[g];
        end else begin : g_ln
            assign sv = vpipe[g-1];
            assign sa = apipe[g-1];
        end

        assign s_readdata[g] = sv ? slave_val(sa) : junk;

        soc1_sysid_arbiter #(
            .ADDR_W(1),
            .DATA_W(32),
            .READ_LATENCY(g)
        ) u_dut (
            .clock            (clock),
            .reset            (reset),
            .m0_address       (m0_address[g]),
            .m0_read          (m0_read[g]),
            .m0_waitrequest   (m0_waitrequest[g]),
            .m0_readdata      (m0_readdata[g]),
            .m0_readdatavalid (m0_readdatavalid[g]),
            .m1_address       (m1_address[g]),
            .m1_read          (m1_read[g]),
            .m1_waitrequest   (m1_waitrequest[g]),
            .m1_readdata      (m1_readdata[g]),
            .m1_readdatavalid (m1_readdatavalid[g]),
            .s_address        (s_address[g]),
            .s_read           (s_read[g]),
            .s_readdata       (s_readdata[g]),
            .busy             (busy[g])
        );
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int lane     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lane=%0d t=%0t got=%h expected=%h", tag, lane, $time, got, exp);
        end
    endtask

    // Reference model: ph counts cycles since acceptance (0 = idle)
    int          ph     = 0;
    bit          last_g = 1'b1;
    bit          owner  = 1'b0;
    logic        m_addr = 1'b0;
    logic [31:0] cap    = '0;
    bit          acc0   = 1'b0;
    bit          acc1   = 1'b0;
    int          grants [2];

    task automatic model_cycle();
        bit   gv;
        bit   gs;
        int   lat;
        logic r0;
        logic r1;
        lat = lane;
        r0  = m0_read[lane];
        r1  = m1_read[lane];
        if (reset) begin
            ph     = 0;
            last_g = 1'b1;
            cap    = '0;
        end
        gv = 1'b0;
        gs = 1'b0;
        if (!reset && ph == 0 && (r0 || r1)) begin
            gv = 1'b1;
            gs = (r0 && r1) ? !last_g : r1;
        end
        check("m0_waitrequest",   32'(m0_waitrequest[lane]),   32'(!(gv && !gs)));
        check("m1_waitrequest",   32'(m1_waitrequest[lane]),   32'(!(gv && gs)));
        check("m0_readdatavalid", 32'(m0_readdatavalid[lane]), 32'(ph == 2 + lat && !owner));
        check("m1_readdatavalid", 32'(m1_readdatavalid[lane]), 32'(ph == 2 + lat && owner));
        check("m0_readdata",      m0_readdata[lane],           cap);
        check("m1_readdata",      m1_readdata[lane],           cap);
        check("s_read",           32'(s_read[lane]),           32'(ph == 1));
        check("busy",             32'(busy[lane]),             32'(ph != 0));
        if (ph == 1)
            check("s_address", 32'(s_address[lane]), 32'(m_addr));
        if (reset)
            check("s_address_rst", 32'(s_address[lane]), 32'd0);
        acc0 = gv && !gs;
        acc1 = gv && gs;
        if (!reset) begin
            if (ph == 0) begin
                if (gv) begin
                    ph     = 1;
                    owner  = gs;
                    last_g = gs;
                    m_addr = gs ? m1_address[lane] : m0_address[lane];
                    grants[gs]++;
                end
            end else begin
                if (ph == 1 + lat) cap = slave_val(m_addr);
                ph = (ph == 2 + lat) ? 0 : ph + 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_master(input int j, input bit accepted, input bit cont);
        logic r;
        logic a;
        r = (j == 0) ? m0_read[lane]    : m1_read[lane];
        a = (j == 0) ? m0_address[lane] : m1_address[lane];
        if (accepted) begin
            // After acceptance the master may change anything freely
            a = 1'($urandom_range(0, 1));
            r = cont ? 1'b1 : 1'($urandom_range(0, 1));
        end else if (!r) begin
            if (cont || $urandom_range(0, 3) == 0) begin
                r = 1'b1;
                a = 1'($urandom_range(0, 1));
            end
        end
        if (j == 0) begin
            m0_read[lane]    = r;
            m0_address[lane] = a;
        end else begin
            m1_read[lane]    = r;
            m1_address[lane] = a;
        end
    endtask

    task automatic run_lane(input bit cont, input int ncyc);
        int rst_left;
        @(posedge clock);
        #1;
        reset             = 1'b1;
        rst_left          = 2;
        m0_read[lane]     = cont;
        m1_read[lane]     = cont;
        m0_address[lane]  = 1'($urandom_range(0, 1));
        m1_address[lane]  = 1'($urandom_range(0, 1));
        grants[0]         = 0;
        grants[1]         = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            model_cycle();
            @(posedge clock);
            #1;
            if (rst_left > 0) rst_left--;
            if (rst_left == 0 && !cont && $urandom_range(0, 39) == 0)
                rst_left = $urandom_range(1, 2);
            reset = (rst_left > 0);
            drive_master(0, acc0, cont);
            drive_master(1, acc1, cont);
        end
        // Under continuous contention grants alternate, so counts differ by at most one
        if (cont) begin
            check("fair_m0_ge_m1", 32'(grants[0] >= grants[1]), 32'd1);
            check("fair_diff_le1", 32'(grants[0] - grants[1] <= 1), 32'd1);
        end
        m0_read[lane] = 1'b0;
        m1_read[lane] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            m0_address[i] = 1'b0;
            m0_read[i]    = 1'b0;
            m1_address[i] = 1'b0;
            m1_read[i]    = 1'b0;
        end
        for (int l = 0; l < N; l++) begin
            lane = l;
            run_lane(1'b1, 40);
            run_lane(1'b0, 300);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
